dm163_row_scanner: RTL and testbench

- Upstream frame-refresh stage for the DM163 colour shield driver.
- Reads 24-bit RGB pixels from a frame buffer through a synchronous read port, serializes one row at a time onto the DM163 serial bus (s_sda/s_clk/lat), and drives the one-hot row/channel select with blanking.
- Gives a continuous multiplexed refresh.
- Shifting of row r+1 overlaps the display of row r; the DM163 latch makes the swap.

---
 rtl/dm163_row_scanner.sv | 206 ++++++++++++++++++++
 tb/tb_dm163_row_scanner.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm163_row_scanner.sv
// dm163_row_scanner: frame-buffer to DM163 serial refresh engine.
// Fetches one row of 24-bit pixels, shifts it out MSB first on s_sda/s_clk
// while the previous row is still lit, then blanks, latches and lights the
// freshly shifted row.
// Optional build macro DM163_SCANNER_DIM_EN adds a 4-bit dim input that
// switches each row off before the end of its hold time.
module dm163_row_scanner #(
   parameter int N_ROWS    = 8,
   parameter int N_COLS    = 8,
   parameter int CLK_DIV   = 2,
   parameter int ROW_HOLD  = 1024,
   parameter int BLANK_CYC = 4
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        enable,
`ifdef DM163_SCANNER_DIM_EN
   input  logic [3:0]                                  dim,
`endif
   output logic                                        fb_rd,
   output logic [$clog2(N_ROWS)+$clog2(N_COLS)-1:0]    fb_addr,
   input  logic [23:0]                                 fb_data,
   output logic                                        s_sda,
   output logic                                        s_clk,
   output logic                                        lat,
   output logic [N_ROWS-1:0]                           channel,
   output logic                                        frame_start,
   output logic                                        busy
);

   localparam int ROW_W  = $clog2(N_ROWS);
   localparam int COL_W  = $clog2(N_COLS);
   localparam int HOLD_W = $clog2(ROW_HOLD) + 1;
   localparam int DIV_W  = $clog2(2 * CLK_DIV);
   localparam int BLK_W  = $clog2(BLANK_CYC);

   localparam logic [HOLD_W-1:0] HOLD_MAX = '1;
   localparam logic [HOLD_W-1:0] HOLD_TGT = HOLD_W'(ROW_HOLD);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_HIGH = DIV_W'(CLK_DIV - 1);
   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(N_COLS - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(N_ROWS - 1);
   localparam logic [BLK_W-1:0]  BLK_SHOW = BLK_W'(BLANK_CYC - 2);
   localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'(BLANK_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      SHIFT,
      HOLDWAIT,
      BLANK
   } state_t;

   state_t              state;
   logic [ROW_W-1:0]    row;
   logic [COL_W-1:0]    col;
   logic [22:0]         shreg;
   logic [4:0]          bit_cnt;
   logic [DIV_W-1:0]    div_cnt;
   logic [BLK_W-1:0]    blank_cnt;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [ROW_W-1:0]    row_next;
   logic [N_ROWS-1:0]   row_onehot;
   logic                dim_cut;

   assign row_next   = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
   assign row_onehot = N_ROWS'(1) << row;

`ifdef DM163_SCANNER_DIM_EN
   // Dimming turns the lit row off once the hold counter passes a threshold
   // that moves earlier by ROW_HOLD/16 per dim step; dim=0 never cuts.
   localparam int HOLD_STEP = ROW_HOLD >> 4;
   logic [HOLD_W+3:0] dim_thresh;
   assign dim_thresh = (HOLD_W+4)'(ROW_HOLD) - (HOLD_W+4)'(dim) * (HOLD_W+4)'(HOLD_STEP);
   assign dim_cut    = (dim != 4'd0) && ({4'b0000, hold_cnt} >= dim_thresh);
`else
   assign dim_cut = 1'b0;
`endif

   // Scan sequencer: every output is assigned on the transition into the
   // state it belongs to, so what is seen on the pins matches the state.
   // Within a bit, s_sda changes at the start of the low half and s_clk
   // rises halfway, giving the DM163 a full half-period of setup.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         row         <= '0;
         col         <= '0;
         shreg       <= '0;
         bit_cnt     <= '0;
         div_cnt     <= '0;
         blank_cnt   <= '0;
         hold_cnt    <= '0;
         fb_rd       <= 1'b0;
         fb_addr     <= '0;
         s_sda       <= 1'b0;
         s_clk       <= 1'b0;
         lat         <= 1'b0;
         channel     <= '0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
      end else begin
         fb_rd       <= 1'b0;
         lat         <= 1'b0;
         frame_start <= 1'b0;
         if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
         end

         case (state)
            IDLE: begin
               channel <= '0;
               busy    <= 1'b0;
               if (enable) begin
                  row      <= '0;
                  col      <= COL_LAST;
                  hold_cnt <= HOLD_MAX;
                  fb_rd    <= 1'b1;
                  fb_addr  <= {ROW_W'(0), COL_LAST};
                  busy     <= 1'b1;
                  state    <= FETCH;
               end
            end

            FETCH: begin
               state <= WAIT;
            end

            WAIT: begin
               s_sda   <= fb_data[23];
               shreg   <= fb_data[22:0];
               bit_cnt <= '0;
               div_cnt <= '0;
               state   <= SHIFT;
            end

            SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  s_clk   <= 1'b0;
                  if (bit_cnt == 5'd23) begin
                     if (col != '0) begin
                        col     <= col - COL_W'(1);
                        fb_rd   <= 1'b1;
                        fb_addr <= {row, col - COL_W'(1)};
                        state   <= FETCH;
                     end else begin
                        state <= HOLDWAIT;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                     s_sda   <= shreg[22];
                     shreg   <= {shreg[21:0], 1'b0};
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
                  s_clk   <= (div_cnt >= DIV_HIGH);
               end
            end

            HOLDWAIT: begin
               if (hold_cnt >= HOLD_TGT) begin
                  channel   <= '0;
                  blank_cnt <= '0;
                  state     <= BLANK;
               end
            end

            BLANK: begin
               blank_cnt <= blank_cnt + BLK_W'(1);
               if (blank_cnt == '0) begin
                  lat <= 1'b1;
               end
               if (blank_cnt == BLK_SHOW) begin
                  channel     <= row_onehot;
                  hold_cnt    <= '0;
                  frame_start <= (row == '0);
               end
               if (blank_cnt == BLK_LAST) begin
                  row <= row_next;
                  col <= COL_LAST;
                  if (enable) begin
                     fb_rd   <= 1'b1;
                     fb_addr <= {row_next, COL_LAST};
                     state   <= FETCH;
                  end else begin
                     channel <= '0;
                     busy    <= 1'b0;
                     state   <= IDLE;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase

         if (dim_cut && state != IDLE && state != BLANK) begin
            channel <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dm163_row_scanner.sv
// tb_dm163_row_scanner: drives two scanners (default hold, and a short hold
// where shifting dominates) from randomized frame buffers and checks the
// serial stream, latch, row select and timing against a row-level model.
`timescale 1ns/1ps
module tb_dm163_row_scanner;

   localparam int N_ROWS    = 8;
   localparam int N_COLS    = 8;
   localparam int CLK_DIV   = 2;
   localparam int ROW_HOLD  = 1024;
   localparam int BLANK_CYC = 4;
   localparam int FAST_HOLD = 10;
   localparam int SHIFT_CYC = N_COLS * (2 + 48 * CLK_DIV);
   localparam int GAP_SLOW  = ROW_HOLD + BLANK_CYC;
   localparam int GAP_FAST  = SHIFT_CYC + BLANK_CYC + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_v        [2];
   logic        fb_rd_v     [2];
   logic [5:0]  fb_addr_v   [2];
   logic [23:0] fb_data_v   [2];
   logic        s_sda_v     [2];
   logic        s_clk_v     [2];
   logic        lat_v       [2];
   logic [7:0]  channel_v   [2];
   logic        fs_v        [2];
   logic        busy_v      [2];

   logic [23:0] mem [2][64];

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;

   int          nbits     [2];
   int          fetch_cnt [2];
   int          next_row  [2];
   int          shown_row [2];
   int          en_count  [2];
   int          fs_count  [2];
   int          last_en   [2];
   logic        prev_sclk [2];
   logic [7:0]  prev_ch   [2];
   logic [191:0] got      [2];

   always #5 clk = ~clk;

   dm163_row_scanner #(
      .N_ROWS(N_ROWS), .N_COLS(N_COLS), .CLK_DIV(CLK_DIV),
      .ROW_HOLD(ROW_HOLD), .BLANK_CYC(BLANK_CYC)
   ) dut (
      .clk(clk), .rst(rst), .enable(en_v[0]),
      .fb_rd(fb_rd_v[0]), .fb_addr(fb_addr_v[0]), .fb_data(fb_data_v[0]),
      .s_sda(s_sda_v[0]), .s_clk(s_clk_v[0]), .lat(lat_v[0]),
      .channel(channel_v[0]), .frame_start(fs_v[0]), .busy(busy_v[0])
   );

   dm163_row_scanner #(
      .N_ROWS(N_ROWS), .N_COLS(N_COLS), .CLK_DIV(CLK_DIV),
      .ROW_HOLD(FAST_HOLD), .BLANK_CYC(BLANK_CYC)
   ) dut_fast (
      .clk(clk), .rst(rst), .enable(en_v[1]),
      .fb_rd(fb_rd_v[1]), .fb_addr(fb_addr_v[1]), .fb_data(fb_data_v[1]),
      .s_sda(s_sda_v[1]), .s_clk(s_clk_v[1]), .lat(lat_v[1]),
      .channel(channel_v[1]), .frame_start(fs_v[1]), .busy(busy_v[1])
   );

   // Count one comparison and report it if observed differs from expected.
   task automatic checkOutput(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Drive reset and both enables just after a rising edge, then wait.
   task automatic applyStimulus(input logic r, input logic e0, input logic e1, input int cycles);
      @(posedge clk);
      #1;
      rst     = r;
      en_v[0] = e0;
      en_v[1] = e1;
      repeat (cycles) @(posedge clk);
   endtask

   // Whole row as it must appear on the wire: column N_COLS-1 first, R7 first.
   function automatic logic [191:0] rowBits(input int d, input int r);
      logic [191:0] v;
      logic [5:0]   a;
      v = '0;
      for (int c = N_COLS - 1; c >= 0; c--) begin
         a = 6'(r * N_COLS + c);
         v = {v[167:0], mem[d][a]};
      end
      return v;
   endfunction

   function automatic logic [5:0] expAddr(input int n);
      int r;
      int c;
      r = (n / N_COLS) % N_ROWS;
      c = N_COLS - 1 - (n % N_COLS);
      return 6'(r * N_COLS + c);
   endfunction

   // Synchronous frame buffer read port: data one cycle after the strobe.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (fb_rd_v[d]) fb_data_v[d] <= mem[d][fb_addr_v[d]];
      end
   end

   // Row-level reference: collects serial bits per latch, predicts the
   // fetch order, the row that lights after each latch and the row spacing.
   always @(negedge clk) begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            nbits[d]     = 0;
            fetch_cnt[d] = 0;
            next_row[d]  = 0;
            shown_row[d] = 0;
            en_count[d]  = 0;
            fs_count[d]  = 0;
            last_en[d]   = -1;
            prev_sclk[d] = 1'b0;
            prev_ch[d]   = '0;
            got[d]       = '0;
         end else begin
            logic rise;
            if (fb_rd_v[d]) begin
               checkOutput("fb_addr", 192'(fb_addr_v[d]), 192'(expAddr(fetch_cnt[d])));
               fetch_cnt[d]++;
            end
            if (s_clk_v[d] && !prev_sclk[d]) begin
               got[d] = {got[d][190:0], s_sda_v[d]};
               nbits[d]++;
            end
            if (lat_v[d]) begin
               checkOutput("lat_clash", 192'({s_clk_v[d], |channel_v[d]}), 192'(0));
               checkOutput("bit_count", 192'(nbits[d]), 192'(24 * N_COLS));
               checkOutput("row_data", got[d], rowBits(d, next_row[d]));
               nbits[d]     = 0;
               shown_row[d] = next_row[d];
               next_row[d]  = (next_row[d] + 1) % N_ROWS;
            end
            rise = (channel_v[d] != 8'h00) && (prev_ch[d] == 8'h00);
            if (rise) begin
               checkOutput("channel", 192'(channel_v[d]), 192'(8'h01 << shown_row[d]));
               if (last_en[d] >= 0)
                  checkOutput("row_gap", 192'(cyc - last_en[d]), 192'((d == 0) ? GAP_SLOW : GAP_FAST));
               last_en[d] = cyc;
               en_count[d]++;
            end
            if (fs_v[d] || rise) begin
               checkOutput("frame_start", 192'(fs_v[d]), 192'(rise && shown_row[d] == 0));
               if (fs_v[d]) fs_count[d]++;
            end
            prev_sclk[d] = s_clk_v[d];
            prev_ch[d]   = channel_v[d];
         end
      end
   end

   initial begin
      int guard;
      rst     = 1'b1;
      en_v[0] = 1'b0;
      en_v[1] = 1'b0;
      for (int i = 0; i < 64; i++) begin
         mem[0][i] = 24'h000000;
         mem[1][i] = 24'($urandom);
      end
      mem[0][7] = 24'hFF0000;
      applyStimulus(1'b1, 1'b0, 1'b0, 3);

      // Idle with enable low: everything stays quiet.
      applyStimulus(1'b0, 1'b0, 1'b0, 0);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         checkOutput("idle_outputs",
            192'({fb_rd_v[0], fb_addr_v[0], s_sda_v[0], s_clk_v[0], lat_v[0], channel_v[0], fs_v[0], busy_v[0]}),
            192'(0));
      end

      // Continuous scan of a full frame plus wrap on both scanners.
      applyStimulus(1'b0, 1'b1, 1'b1, 0);
      guard = 0;
      while (en_count[0] < 9 && guard < 12000) begin
         @(posedge clk);
         guard++;
      end
      checkOutput("timeout_frame", 192'(guard >= 12000), 192'(0));
      checkOutput("frame_starts", 192'(fs_count[0]), 192'(2));
      checkOutput("fast_rows", 192'(en_count[1] >= 9), 192'(1));

      // Drop enable while row 3 is shifting: row 3 still shows, then idle.
      for (int i = 0; i < 64; i++) begin
         mem[0][i] = 24'($urandom);
         mem[1][i] = 24'($urandom);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 2);
      applyStimulus(1'b0, 1'b1, 1'b0, 0);
      guard = 0;
      while (fetch_cnt[0] < 3 * N_COLS + 1 && guard < 6000) begin
         @(posedge clk);
         guard++;
      end
      checkOutput("timeout_row3", 192'(guard >= 6000), 192'(0));
      applyStimulus(1'b0, 1'b0, 1'b0, 30);
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (busy_v[0] && guard < 3000);
      checkOutput("timeout_idle", 192'(guard >= 3000), 192'(0));
      checkOutput("stop_channel", 192'(channel_v[0]), 192'(0));
      checkOutput("stop_rows", 192'(en_count[0]), 192'(4));
      checkOutput("stop_last_row", 192'(shown_row[0]), 192'(3));
      repeat (200) @(negedge clk);
      checkOutput("stop_fetches", 192'(fetch_cnt[0]), 192'(4 * N_COLS));
      checkOutput("stop_busy", 192'(busy_v[0]), 192'(0));

      // Reset pulse in the middle of a column shift, then restart.
      for (int i = 0; i < 64; i++) mem[0][i] = 24'($urandom);
      applyStimulus(1'b1, 1'b0, 1'b0, 2);
      applyStimulus(1'b0, 1'b1, 1'b0, 0);
      guard = 0;
      while (fetch_cnt[0] < 12 && guard < 3000) begin
         @(posedge clk);
         guard++;
      end
      checkOutput("timeout_mid", 192'(guard >= 3000), 192'(0));
      repeat (20) @(posedge clk);
      applyStimulus(1'b1, 1'b1, 1'b0, 1);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_outputs",
         192'({fb_rd_v[0], fb_addr_v[0], s_sda_v[0], s_clk_v[0], lat_v[0], channel_v[0], fs_v[0], busy_v[0]}),
         192'(0));
      guard = 0;
      while (en_count[0] < 2 && guard < 3000) begin
         @(posedge clk);
         guard++;
      end
      checkOutput("timeout_restart", 192'(guard >= 3000), 192'(0));
      checkOutput("restart_rows", 192'(shown_row[0]), 192'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
